// File: rtl/gbt_reset_sequencer_pkg.sv
// gbt_reset_sequencer_pkg
//   Shared types and constants for the GBT link reset sequencer.
//   - t_gbt_rst_state : 4-bit encoded sequencer state. This encoding is also the
//                       value exported on state_o for the debug/PS register.
//   - t_gbt_rst_out   : the registered control/status outputs of one state.
//   - default cycle, timeout and retry constants.
//   - state_outputs() : maps a state to its output levels.
//   - max3()          : sizes the shared millisecond counter.
package gbt_reset_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_MGT_RST  = 4'd1,
    ST_WAIT_PLL = 4'd2,
    ST_TX_RST   = 4'd3,
    ST_WAIT_TX  = 4'd4,
    ST_RX_RST   = 4'd5,
    ST_WAIT_RX  = 4'd6,
    ST_LINKED   = 4'd7,
    ST_RETRY    = 4'd8,
    ST_FAILED   = 4'd9
  } t_gbt_rst_state;

  typedef struct packed {
    logic mgt_reset;
    logic tx_reset;
    logic rx_reset;
    logic busy;
    logic linked;
    logic fail;
  } t_gbt_rst_out;

  localparam int unsigned C_MGT_RST_CYCLES = 16;
  localparam int unsigned C_PLL_TIMEOUT_MS = 10;
  localparam int unsigned C_TX_TIMEOUT_MS  = 100;
  localparam int unsigned C_RX_TIMEOUT_MS  = 500;
  localparam int unsigned C_MAX_RETRIES    = 7;
  localparam int unsigned C_RETRY_W        = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Reset lines are held asserted everywhere the link is not being brought up
  // (MGT_RST, RETRY, FAILED) and released one stage at a time as the sequence
  // advances.
  function automatic t_gbt_rst_out state_outputs(input t_gbt_rst_state s);
    t_gbt_rst_out o;
    o = '{mgt_reset: 1'b1, tx_reset: 1'b1, rx_reset: 1'b1,
          busy: 1'b1, linked: 1'b0, fail: 1'b0};
    case (s)
      ST_IDLE:     begin o.mgt_reset = 1'b0; o.tx_reset = 1'b0; o.rx_reset = 1'b0;
                         o.busy = 1'b0; end
      ST_MGT_RST:  ;
      ST_WAIT_PLL: o.mgt_reset = 1'b0;
      ST_TX_RST:   o.mgt_reset = 1'b0;
      ST_WAIT_TX:  begin o.mgt_reset = 1'b0; o.tx_reset = 1'b0; end
      ST_RX_RST:   begin o.mgt_reset = 1'b0; o.tx_reset = 1'b0; end
      ST_WAIT_RX:  begin o.mgt_reset = 1'b0; o.tx_reset = 1'b0; o.rx_reset = 1'b0; end
      ST_LINKED:   begin o.mgt_reset = 1'b0; o.tx_reset = 1'b0; o.rx_reset = 1'b0;
                         o.busy = 1'b0; o.linked = 1'b1; end
      ST_RETRY:    ;
      ST_FAILED:   begin o.busy = 1'b0; o.fail = 1'b1; end
      default:     ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/gbt_reset_sequencer_ms_timeout_counter.sv
// gbt_reset_sequencer_ms_timeout_counter
//   Millisecond timeout counter shared by all waiting states of the sequencer.
//   The count restarts from zero on clear_i, advances once per tick_i and
//   saturates at limit_i. expired_o is a single-cycle pulse raised when a tick
//   arrives while the count already equals the limit.
// Ports
//   clk_ik    in  clock
//   rst_ir    in  async reset, active high
//   clear_i   in  restart the count (state entry)
//   tick_i    in  1 ms enable
//   limit_i   in  CNT_W  timeout limit in ms for the current state
//   expired_o out timeout pulse
module gbt_reset_sequencer_ms_timeout_counter #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk_ik,
  input  logic             rst_ir,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating at the limit keeps states without a timeout from wrapping
  // the count around and firing a spurious expiry later.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (tick_i && (cnt_q != limit_i))
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign expired_o = tick_i && (cnt_q == limit_i);

  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gbt_reset_sequencer.sv
// gbt_reset_sequencer
//   Ordered GTH/GBT bring-up launched on reset release or on a restart request:
//   MGT reset, PLL lock, TX reset, TX ready, RX reset, RX ready, then LINKED.
//   Timeouts restart the sequence up to g_max_retries times before FAILED.
// Ports
//   clk_ik            in   120 MHz clock
//   rst_ir            in   async reset, active high
//   tick_ms_i         in   1-cycle enable once per ms
//   req_i             in   restart request (rising edge)
//   los_i             in   optical loss of signal
//   mgt_pll_locked_i  in   GTH PLL lock
//   tx_ready_i        in   GBT TX ready
//   rx_ready_i        in   GBT RX ready
//   mgt_reset_o       out  GTH reset
//   tx_reset_o        out  GBT TX reset
//   rx_reset_o        out  GBT RX reset
//   busy_o            out  sequence in progress
//   linked_o          out  LINKED state
//   fail_o            out  FAILED state
//   retry_cnt_o       out  [3:0] restarts since last request
//   state_o           out  [3:0] encoded state
// Configuration
//   GBT_RST_SEQ_AUTO_RELINK_EN : when defined, LINKED drops to RETRY after
//   rx_ready_i is seen low on two consecutive ms ticks, and FAILED restarts on
//   a falling edge of los_i. Otherwise LINKED/FAILED leave only on req_i.
module gbt_reset_sequencer
  import gbt_reset_sequencer_pkg::*;
#(
  parameter int unsigned g_mgt_rst_cycles = C_MGT_RST_CYCLES,
  parameter int unsigned g_pll_timeout_ms = C_PLL_TIMEOUT_MS,
  parameter int unsigned g_tx_timeout_ms  = C_TX_TIMEOUT_MS,
  parameter int unsigned g_rx_timeout_ms  = C_RX_TIMEOUT_MS,
  parameter int unsigned g_max_retries    = C_MAX_RETRIES
) (
  input  logic                 clk_ik,
  input  logic                 rst_ir,
  input  logic                 tick_ms_i,
  input  logic                 req_i,
  input  logic                 los_i,
  input  logic                 mgt_pll_locked_i,
  input  logic                 tx_ready_i,
  input  logic                 rx_ready_i,
  output logic                 mgt_reset_o,
  output logic                 tx_reset_o,
  output logic                 rx_reset_o,
  output logic                 busy_o,
  output logic                 linked_o,
  output logic                 fail_o,
  output logic [C_RETRY_W-1:0] retry_cnt_o,
  output logic [3:0]           state_o
);

  // Wide enough to hold the largest limit itself.
  localparam int unsigned CNT_W = $clog2(max3(g_pll_timeout_ms, g_tx_timeout_ms,
                                              g_rx_timeout_ms) + 1);
  localparam int unsigned MGT_W = $clog2(g_mgt_rst_cycles);
  localparam logic [MGT_W-1:0]     MGT_LAST  = MGT_W'(g_mgt_rst_cycles - 1);
  localparam logic [C_RETRY_W-1:0] RETRY_MAX = C_RETRY_W'(g_max_retries);

  // Synchroniser bit positions
  localparam int unsigned I_TICK = 0;
  localparam int unsigned I_REQ  = 1;
  localparam int unsigned I_LOS  = 2;
  localparam int unsigned I_PLL  = 3;
  localparam int unsigned I_TX   = 4;
  localparam int unsigned I_RX   = 5;

  t_gbt_rst_state       state_q, state_d;
  t_gbt_rst_out         out_q, out_d;
  logic [5:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic                 req_prev_q, req_prev_d, los_prev_q, los_prev_d;
  logic [MGT_W-1:0]     mgt_cyc_q, mgt_cyc_d;
  logic [C_RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0]     limit;
  logic                 tick_s, req_s, los_s, pll_s, tx_s, rx_s;
  logic                 req_rise, los_rise, pll_lost, restart, enter, expired;
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
  logic                 relink_low_q, relink_low_d;
  logic                 los_fall;
`endif

  // The ms tick goes through the same two stages as the status inputs so that
  // a tick and a ready edge arriving together are also seen together.
  assign sync1_d = {rx_ready_i, tx_ready_i, mgt_pll_locked_i, los_i, req_i, tick_ms_i};
  assign sync2_d = sync1_q;

  assign tick_s = sync2_q[I_TICK];
  assign req_s  = sync2_q[I_REQ];
  assign los_s  = sync2_q[I_LOS];
  assign pll_s  = sync2_q[I_PLL];
  assign tx_s   = sync2_q[I_TX];
  assign rx_s   = sync2_q[I_RX];

  assign req_prev_d = req_s;
  assign los_prev_d = los_s;
  assign req_rise   = req_s & ~req_prev_q;
  assign los_rise   = los_s & ~los_prev_q;
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
  assign los_fall   = ~los_s & los_prev_q;
`endif

  // Once the PLL has locked, every later state depends on it.
  always_comb begin
    pll_lost = 1'b0;
    case (state_q)
      ST_TX_RST, ST_WAIT_TX, ST_RX_RST, ST_WAIT_RX, ST_LINKED: pll_lost = ~pll_s;
      default: ;
    endcase
  end

  always_comb begin
    limit = '1;
    case (state_q)
      ST_WAIT_PLL: limit = CNT_W'(g_pll_timeout_ms);
      ST_WAIT_TX:  limit = CNT_W'(g_tx_timeout_ms);
      ST_WAIT_RX:  limit = CNT_W'(g_rx_timeout_ms);
      default: ;
    endcase
  end

  gbt_reset_sequencer_ms_timeout_counter #(.CNT_W(CNT_W)) u_ms_cnt (
    .clk_ik    (clk_ik),
    .rst_ir    (rst_ir),
    .clear_i   (enter),
    .tick_i    (tick_s),
    .limit_i   (limit),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    restart     = 1'b0;
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
    relink_low_d = relink_low_q;
`endif
    if (req_rise) begin
      state_d     = ST_MGT_RST;
      retry_cnt_d = '0;
      restart     = 1'b1;
    end else if (pll_lost) begin
      state_d = ST_RETRY;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_MGT_RST:
          if (mgt_cyc_q == MGT_LAST) state_d = ST_WAIT_PLL;
        // Ready is tested before the timeout so it wins a same-cycle tie.
        ST_WAIT_PLL:
          if (pll_s)        state_d = ST_TX_RST;
          else if (expired) state_d = ST_RETRY;
        ST_TX_RST:
          state_d = ST_WAIT_TX;
        ST_WAIT_TX:
          if (tx_s)         state_d = ST_RX_RST;
          else if (expired) state_d = ST_RETRY;
        // No timeout here: the far end may legitimately be dark for a long time.
        ST_RX_RST:
          if (!los_s)       state_d = ST_WAIT_RX;
        ST_WAIT_RX:
          if (rx_s)                     state_d = ST_LINKED;
          else if (expired || los_rise) state_d = ST_RETRY;
        ST_LINKED: begin
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
          if (tick_s && !rx_s && relink_low_q) state_d = ST_RETRY;
`endif
        end
        // The counter shows restarts taken, so the final timeout that lands in
        // FAILED leaves it at g_max_retries.
        ST_RETRY:
          if (retry_cnt_q == RETRY_MAX) begin
            state_d = ST_FAILED;
          end else begin
            state_d = ST_MGT_RST;
            if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + C_RETRY_W'(1);
          end
        ST_FAILED: begin
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
          if (los_fall) begin
            state_d     = ST_MGT_RST;
            retry_cnt_d = '0;
            restart     = 1'b1;
          end
`endif
        end
        default: state_d = ST_MGT_RST;
      endcase
    end
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
    // Remembers one tick already seen with rx_ready low while LINKED.
    if (state_q != ST_LINKED || rx_s) relink_low_d = 1'b0;
    else if (tick_s)                  relink_low_d = 1'b1;
`endif
  end

  // A restart into the state already held still counts as an entry.
  assign enter = restart || (state_d != state_q);

  always_comb begin
    mgt_cyc_d = mgt_cyc_q;
    if (enter)                                              mgt_cyc_d = '0;
    else if (state_q == ST_MGT_RST && mgt_cyc_q != MGT_LAST) mgt_cyc_d = mgt_cyc_q + MGT_W'(1);
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as state_q.
  assign out_d = state_outputs(state_d);

  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) begin
      state_q      <= ST_MGT_RST;
      out_q        <= state_outputs(ST_MGT_RST);
      sync1_q      <= '0;
      sync2_q      <= '0;
      req_prev_q   <= 1'b0;
      los_prev_q   <= 1'b0;
      mgt_cyc_q    <= '0;
      retry_cnt_q  <= '0;
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
      relink_low_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      req_prev_q   <= req_prev_d;
      los_prev_q   <= los_prev_d;
      mgt_cyc_q    <= mgt_cyc_d;
      retry_cnt_q  <= retry_cnt_d;
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
      relink_low_q <= relink_low_d;
`endif
    end
  end

  assign mgt_reset_o = out_q.mgt_reset;
  assign tx_reset_o  = out_q.tx_reset;
  assign rx_reset_o  = out_q.rx_reset;
  assign busy_o      = out_q.busy;
  assign linked_o    = out_q.linked;
  assign fail_o      = out_q.fail;
  assign retry_cnt_o = retry_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_gbt_reset_sequencer.sv
// tb_gbt_reset_sequencer
//   Directed bench for gbt_reset_sequencer with default parameters. Ticks are
//   generated by the bench every TICK_P cycles so every timeout boundary is
//   known exactly. Expectations for the LINKED rx_ready drop depend on
//   GBT_RST_SEQ_AUTO_RELINK_EN.
module tb_gbt_reset_sequencer;

  localparam int TICK_P = 4;
  localparam int S_MGT  = 1, S_WPLL = 2, S_WTX = 4, S_RXR = 5, S_WRX = 6,
                 S_LNK  = 7, S_FAIL = 9;

  logic       clk_ik = 1'b0, rst_ir = 1'b1;
  logic       tick_ms_i = 1'b0, req_i = 1'b0, los_i = 1'b0;
  logic       mgt_pll_locked_i = 1'b0, tx_ready_i = 1'b0, rx_ready_i = 1'b0;
  logic       mgt_reset_o, tx_reset_o, rx_reset_o, busy_o, linked_o, fail_o;
  logic [3:0] retry_cnt_o, state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int hits;
  int base;

  gbt_reset_sequencer dut (
    .clk_ik           (clk_ik),
    .rst_ir           (rst_ir),
    .tick_ms_i        (tick_ms_i),
    .req_i            (req_i),
    .los_i            (los_i),
    .mgt_pll_locked_i (mgt_pll_locked_i),
    .tx_ready_i       (tx_ready_i),
    .rx_ready_i       (rx_ready_i),
    .mgt_reset_o      (mgt_reset_o),
    .tx_reset_o       (tx_reset_o),
    .rx_reset_o       (rx_reset_o),
    .busy_o           (busy_o),
    .linked_o         (linked_o),
    .fail_o           (fail_o),
    .retry_cnt_o      (retry_cnt_o),
    .state_o          (state_o)
  );

  always #5 clk_ik = ~clk_ik;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_ik);
      #1;
    end
  endtask

  task automatic ms(input int n);
    repeat (n) begin
      tick_ms_i = 1'b1;
      cyc(1);
      tick_ms_i = 1'b0;
      cyc(TICK_P - 1);
    end
  endtask

  task automatic pulse_req();
    req_i = 1'b1;
    cyc(1);
    req_i = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_state",  32'(state_o),     S_MGT);
    chk("rst_mgt",    32'(mgt_reset_o), 1);
    chk("rst_tx",     32'(tx_reset_o),  1);
    chk("rst_rx",     32'(rx_reset_o),  1);
    chk("rst_busy",   32'(busy_o),      1);
    chk("rst_linked", 32'(linked_o),    0);
    chk("rst_fail",   32'(fail_o),      0);
    chk("rst_retry",  32'(retry_cnt_o), 0);
    rst_ir = 1'b0;

    // Sequence starts on its own; MGT reset lasts 16 cycles
    cyc(15);
    chk("mgt_hold_15", 32'(state_o), S_MGT);
    cyc(1);
    chk("mgt_done_16", 32'(state_o), S_WPLL);
    chk("wpll_mgt",    32'(mgt_reset_o), 0);
    chk("wpll_tx",     32'(tx_reset_o),  1);

    // 1: normal bring-up
    ms(2); mgt_pll_locked_i = 1'b1; cyc(5);
    chk("t1_wtx",    32'(state_o),    S_WTX);
    chk("t1_tx_rst", 32'(tx_reset_o), 0);
    ms(5); tx_ready_i = 1'b1; cyc(5);
    chk("t1_wrx",    32'(state_o),    S_WRX);
    chk("t1_rx_rst", 32'(rx_reset_o), 0);
    ms(8); rx_ready_i = 1'b1; cyc(5);
    chk("t1_state",  32'(state_o),     S_LNK);
    chk("t1_linked", 32'(linked_o),    1);
    chk("t1_busy",   32'(busy_o),      0);
    chk("t1_retry",  32'(retry_cnt_o), 0);

    // TX timeout boundary: fires on the tick after the count reaches 100
    tx_ready_i = 1'b0; rx_ready_i = 1'b0;
    pulse_req(); cyc(40);
    chk("to_wtx", 32'(state_o), S_WTX);
    ms(100);
    chk("to_edge_state", 32'(state_o),     S_WTX);
    chk("to_edge_retry", 32'(retry_cnt_o), 0);
    ms(1);
    chk("to_fire_state", 32'(state_o),     S_MGT);
    chk("to_fire_retry", 32'(retry_cnt_o), 1);
    cyc(25);
    chk("to_back_wtx", 32'(state_o), S_WTX);

    // 4: request mid WAIT_TX
    hits = 0;
    req_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (i == 0) req_i = 1'b0;
      if (mgt_reset_o) hits++;
    end
    chk("t4_mgt_width", 32'(hits),        16);
    chk("t4_retry",     32'(retry_cnt_o), 0);
    chk("t4_wtx",       32'(state_o),     S_WTX);

    // 2: tx_ready stuck low -> 7 restarts then FAILED
    for (int k = 1; k <= 8; k++) begin
      ms(101);
      if (k < 8) begin
        chk("t2_retry", 32'(retry_cnt_o), 32'(k));
        chk("t2_state", 32'(state_o),     S_MGT);
        cyc(25);
      end
    end
    chk("t2_fail_state", 32'(state_o),     S_FAIL);
    chk("t2_fail",       32'(fail_o),      1);
    chk("t2_retry_end",  32'(retry_cnt_o), 7);
    chk("t2_busy",       32'(busy_o),      0);
    chk("t2_mgt",        32'(mgt_reset_o), 1);
    ms(3);
    chk("t2_stays", 32'(state_o), S_FAIL);
    pulse_req(); cyc(2);
    chk("t2_req_state", 32'(state_o),     S_MGT);
    chk("t2_req_retry", 32'(retry_cnt_o), 0);
    chk("t2_req_fail",  32'(fail_o),      0);

    // 3: los held in RX_RST
    los_i = 1'b1; tx_ready_i = 1'b1;
    cyc(30);
    chk("t3_rxr", 32'(state_o),    S_RXR);
    ms(2000);
    chk("t3_rxr_2s",  32'(state_o),     S_RXR);
    chk("t3_rx_rst",  32'(rx_reset_o),  1);
    chk("t3_retry",   32'(retry_cnt_o), 0);
    los_i = 1'b0; cyc(5);
    chk("t3_wrx",     32'(state_o),    S_WRX);
    chk("t3_rx_rel",  32'(rx_reset_o), 0);

    // 5: rx_ready and the expiring tick together -> ready wins
    ms(500);
    chk("t5_edge", 32'(state_o), S_WRX);
    rx_ready_i = 1'b1;
    ms(1);
    chk("t5_state", 32'(state_o),     S_LNK);
    chk("t5_retry", 32'(retry_cnt_o), 0);

    // 6: rx_ready dropped for 2 ticks while LINKED
    rx_ready_i = 1'b0; cyc(4);
    ms(2);
`ifdef GBT_RST_SEQ_AUTO_RELINK_EN
    chk("t6_state", 32'(state_o),     S_MGT);
    chk("t6_retry", 32'(retry_cnt_o), 1);
    rx_ready_i = 1'b1; cyc(30);
    chk("t6_relink", 32'(state_o), S_LNK);
    base = 1;
`else
    chk("t6_state",  32'(state_o),     S_LNK);
    chk("t6_linked", 32'(linked_o),    1);
    chk("t6_retry",  32'(retry_cnt_o), 0);
    ms(3);
    chk("t6_stays",  32'(state_o), S_LNK);
    rx_ready_i = 1'b1;
    base = 0;
`endif

    // PLL loss while LINKED restarts via RETRY
    cyc(4);
    mgt_pll_locked_i = 1'b0; cyc(4);
    chk("pll_loss_state", 32'(state_o),     S_MGT);
    chk("pll_loss_retry", 32'(retry_cnt_o), 32'(base + 1));
    mgt_pll_locked_i = 1'b1; cyc(30);
    chk("pll_relink", 32'(state_o), S_LNK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
